// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single fixed-latency memory port.
// Owner's request is latched on grant; memory strobes are driven for MEM_LATENCY cycles.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqA,
    input  logic [31:0] AddrA,
    input  logic        WrA,
    input  logic [31:0] WDataA,
    input  logic        ReqB,
    input  logic [31:0] AddrB,
    input  logic        WrB,
    input  logic [31:0] WDataB,
    output logic        GntA,
    output logic        GntB,
    output logic        DoneA,
    output logic        DoneB,
    output logic        Sel,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] MemRData,
    output logic [31:0] RData
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_b_q;
    logic        sel_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        grant_b;
    logic        grant;
    logic        last_cnt;

    // On a tie, B wins only if A was served last.
    assign grant_b  = ReqB & (~ReqA | ~last_b_q);
    assign grant    = (state_q == StIdle) & (ReqA | ReqB);
    assign last_cnt = (cnt_q == 4'(MEM_LATENCY - 1));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = 4'd0;
                if (ReqA | ReqB) state_d = StBusy;
            end
            StBusy: begin
                if (last_cnt) state_d = StDone;
                else          cnt_d   = cnt_q + 4'd1;
            end
            StDone: begin
                cnt_d   = 4'd0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            last_b_q <= 1'b1;
            sel_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            if (grant) begin
                sel_q   <= grant_b;
                wr_q    <= grant_b ? WrB    : WrA;
                addr_q  <= grant_b ? AddrB  : AddrA;
                wdata_q <= grant_b ? WDataB : WDataA;
            end
            if ((state_q == StBusy) && last_cnt) begin
                if (!wr_q) rdata_q <= MemRData;
                last_b_q <= sel_q;
            end
        end
    end

    always_comb begin
        GntA     = (state_q == StBusy) & ~sel_q;
        GntB     = (state_q == StBusy) &  sel_q;
        DoneA    = (state_q == StDone) & ~sel_q;
        DoneB    = (state_q == StDone) &  sel_q;
        MemRead  = (state_q == StBusy) & ~wr_q;
        MemWrite = (state_q == StBusy) &  wr_q;
        Sel      = sel_q;
        MemAddr  = addr_q;
        MemWData = wdata_q;
        RData    = rdata_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LATENCY=2 with hand-computed expectations.
module tb_mem_port_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        ReqA, WrA, ReqB, WrB;
    logic [31:0] AddrA, WDataA, AddrB, WDataB;
    logic        GntA, GntB, DoneA, DoneB, Sel, MemRead, MemWrite;
    logic [31:0] MemAddr, MemWData, MemRData, RData;

    int n_vec = 0;
    int n_err = 0;

    // {GntA, GntB, DoneA, DoneB, Sel, MemRead, MemWrite}
    logic [6:0] stat;
    assign stat = {GntA, GntB, DoneA, DoneB, Sel, MemRead, MemWrite};

    localparam logic [6:0] SIdleA = 7'b0000000;
    localparam logic [6:0] SIdleB = 7'b0000100;
    localparam logic [6:0] SRdA   = 7'b1000010;
    localparam logic [6:0] SRdB   = 7'b0100110;
    localparam logic [6:0] SWrB   = 7'b0100101;
    localparam logic [6:0] SDoneA = 7'b0010000;
    localparam logic [6:0] SDoneB = 7'b0001100;

    mem_port_arbiter #(.MEM_LATENCY(2)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .ReqA     (ReqA),
        .AddrA    (AddrA),
        .WrA      (WrA),
        .WDataA   (WDataA),
        .ReqB     (ReqB),
        .AddrB    (AddrB),
        .WrB      (WrB),
        .WDataB   (WDataB),
        .GntA     (GntA),
        .GntB     (GntB),
        .DoneA    (DoneA),
        .DoneB    (DoneB),
        .Sel      (Sel),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .MemRData (MemRData),
        .RData    (RData)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_stat(input string tag, input logic [6:0] exp);
        n_vec++;
        assert (stat === exp) else begin
            n_err++;
            $error("FAIL %s: stat got %b expected %b", tag, stat, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        Rst = 1'b1;
        ReqA = 1'b0; WrA = 1'b0; AddrA = 32'd0; WDataA = 32'd0;
        ReqB = 1'b0; WrB = 1'b0; AddrB = 32'd0; WDataB = 32'd0;
        MemRData = 32'd0;
        tick();
        tick();
        chk_stat("reset_stat", SIdleA);
        chk32("reset_addr", MemAddr, 32'd0);
        chk32("reset_wdata", MemWData, 32'd0);
        chk32("reset_rdata", RData, 32'd0);
        Rst = 1'b0;

        // A read only
        ReqA = 1'b1; AddrA = 32'h0000_0040; MemRData = 32'hDEAD_BEEF;
        tick();
        chk_stat("a_rd_busy0", SRdA);
        chk32("a_rd_addr0", MemAddr, 32'h0000_0040);
        tick();
        chk_stat("a_rd_busy1", SRdA);
        tick();
        chk_stat("a_rd_done", SDoneA);
        chk32("a_rd_rdata", RData, 32'hDEAD_BEEF);
        ReqA = 1'b0;
        tick();
        chk_stat("a_rd_idle", SIdleA);

        // B write
        ReqB = 1'b1; WrB = 1'b1; AddrB = 32'h1001_0000; WDataB = 32'h1234_5678;
        MemRData = 32'h5555_AAAA;
        tick();
        chk_stat("b_wr_busy0", SWrB);
        chk32("b_wr_addr", MemAddr, 32'h1001_0000);
        chk32("b_wr_wdata", MemWData, 32'h1234_5678);
        tick();
        chk_stat("b_wr_busy1", SWrB);
        tick();
        chk_stat("b_wr_done", SDoneB);
        chk32("b_wr_rdata_kept", RData, 32'hDEAD_BEEF);
        ReqB = 1'b0; WrB = 1'b0;
        tick();
        chk_stat("b_wr_idle_sel_hold", SIdleB);

        // Reset, then both requesters continuously re-request: A first, strict alternation
        Rst = 1'b1;
        tick();
        chk_stat("rst2_stat", SIdleA);
        chk32("rst2_rdata", RData, 32'd0);
        Rst = 1'b0;
        AddrA = 32'h0000_0040; AddrB = 32'h0000_0080;
        ReqA = 1'b1; ReqB = 1'b1;
        for (int acc = 0; acc < 8; acc++) begin
            logic ob;
            ob = acc[0];
            MemRData = 32'hA000_0000 + 32'(acc);
            tick();
            chk_stat("rr_busy0", ob ? SRdB : SRdA);
            chk32("rr_addr", MemAddr, ob ? 32'h0000_0080 : 32'h0000_0040);
            tick();
            chk_stat("rr_busy1", ob ? SRdB : SRdA);
            tick();
            chk_stat("rr_done", ob ? SDoneB : SDoneA);
            chk32("rr_rdata", RData, 32'hA000_0000 + 32'(acc));
            if (ob) ReqB = 1'b0; else ReqA = 1'b0;
            tick();
            chk_stat("rr_idle", ob ? SIdleB : SIdleA);
            if (acc < 7) begin
                if (ob) ReqB = 1'b1; else ReqA = 1'b1;
            end else begin
                ReqA = 1'b0; ReqB = 1'b0;
            end
        end
        tick();
        chk_stat("rr_quiet", SIdleB);

        // Reset in the second BUSY cycle abandons the access
        ReqA = 1'b1; AddrA = 32'h0000_0040; MemRData = 32'h0BAD_0BAD;
        tick();
        chk_stat("abort_busy0", SRdA);
        tick();
        chk_stat("abort_busy1", SRdA);
        Rst = 1'b1;
        tick();
        chk_stat("abort_stat", SIdleA);
        chk32("abort_addr", MemAddr, 32'd0);
        chk32("abort_rdata", RData, 32'd0);
        Rst = 1'b0; ReqA = 1'b0;
        ReqB = 1'b1; AddrB = 32'h0000_0080; MemRData = 32'h7777_1111;
        tick();
        chk_stat("post_abort_busy0", SRdB);
        tick();
        tick();
        chk_stat("post_abort_done", SDoneB);
        chk32("post_abort_rdata", RData, 32'h7777_1111);
        ReqB = 1'b0;
        tick();

        // Requester inputs change mid-BUSY and ReqA drops
        ReqA = 1'b1; AddrA = 32'h0000_0040; MemRData = 32'hCAFE_F00D;
        tick();
        chk_stat("hold_busy0", SRdA);
        AddrA = 32'hFFFF_FFFC; WDataA = 32'h9999_9999; WrA = 1'b1; ReqA = 1'b0;
        chk32("hold_addr0", MemAddr, 32'h0000_0040);
        tick();
        chk_stat("hold_busy1", SRdA);
        chk32("hold_addr1", MemAddr, 32'h0000_0040);
        tick();
        chk_stat("hold_done", SDoneA);
        chk32("hold_rdata", RData, 32'hCAFE_F00D);
        tick();
        chk_stat("hold_idle", SIdleA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, meaning memory access cycles; legal range 1..15.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port Clk, input, 1, rising-edge clock for all state.
REQ-004 SHALL have port Rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ReqA, input, 1, requester A access request (fetch side).
REQ-006 SHALL have port AddrA, input, 32, requester A address.
REQ-007 SHALL have port WrA, input, 1, requester A write (1) / read (0).
REQ-008 SHALL have port WDataA, input, 32, requester A write data.
REQ-009 SHALL have ports ReqB, AddrB, WrB and WDataB, mirroring REQ-005..008 for requester B (data side).
REQ-010 SHALL have port GntA/GntB, output, 1 each, access granted and in progress.
REQ-011 SHALL have port DoneA/DoneB, output, 1 each, one-cycle completion pulse.
REQ-012 SHALL have port Sel, output, 1, address/data mux select: 0 = A, 1 = B.
REQ-013 SHALL have ports MemAddr (32), MemWData (32), MemRead (1) and MemWrite (1), all outputs, driving the shared memory port.
REQ-014 SHALL have port MemRData, input, 32, memory read data, valid in the last BUSY cycle.
REQ-015 SHALL have port RData, output, 32, registered read data for the completed requester.

Function
REQ-016 SHALL implement states IDLE, BUSY and DONE in a registered FSM with a 4-bit latency counter.
REQ-017 In IDLE with only one Req high, SHALL grant that requester at the next edge.
REQ-018 In IDLE with both Req high, SHALL grant the requester not served last (round-robin via a LastB flag).
REQ-019 On grant, SHALL at that edge set Sel, latch address, Wr and WData into holding registers, and enter BUSY with count=0.
REQ-020 In BUSY, SHALL drive Gnt of the owner, MemAddr/MemWData from the holding registers, and MemRead=~Wr or MemWrite=Wr, for exactly MEM_LATENCY cycles.
REQ-021 In the last BUSY cycle, SHALL capture MemRData into RData on reads only (RData unchanged on writes), update LastB, and enter DONE.
REQ-022 In DONE, SHALL pulse the owner's Done for one cycle, deassert Mem* strobes and Gnt, and return to IDLE.
REQ-023 Latency: Req sampled at edge k SHALL yield Done high during cycle k+MEM_LATENCY+1 (no contention).
REQ-024 Requester protocol: Req is held until Done is sampled high and dropped at that edge; IDLE following DONE SHALL therefore see fresh Req only.
REQ-025 Req deasserted during BUSY SHALL NOT abort the access; the access completes and Done still pulses.
REQ-026 Address/data changes on the requester inputs during BUSY SHALL NOT affect Mem* outputs (holding registers).
REQ-027 Sel SHALL remain stable through BUSY and DONE, and SHALL hold its last value in IDLE.
REQ-028 GntA and GntB SHALL never be high simultaneously, and likewise DoneA and DoneB.
REQ-029 MemRead and MemWrite SHALL never be high simultaneously and SHALL be low outside BUSY.

Reset
REQ-030 Rst high at an edge SHALL force IDLE, count=0, LastB=1 (A wins first tie), Sel=0, all Gnt/Done/MemRead/MemWrite=0, and MemAddr, MemWData and RData=0.
REQ-031 Rst during BUSY or DONE SHALL abandon the access immediately with no Done pulse; Rst SHALL take priority over all transitions.

Verification
REQ-032 A read only, MEM_LATENCY=2, AddrA=0x00000040, MemRData=0xDEADBEEF -> GntA high 2 cycles, MemRead high 2 cycles, DoneA pulses 3 cycles after the request edge, RData=0xDEADBEEF, Sel=0.
REQ-033 B write, AddrB=0x10010000, WDataB=0x12345678 -> Sel=1, MemWrite high 2 cycles with MemAddr/MemWData matching, RData unchanged, DoneB pulses once.
REQ-034 ReqA and ReqB rise on the same edge after reset -> A served first, B granted in the IDLE cycle after DoneA; the next tie goes to A since B was last served.
REQ-035 Both requesters continuously re-request for 8 accesses -> strict A/B alternation, no Gnt overlap, no idle cycles other than the one IDLE cycle per access.
REQ-036 Rst asserted in the second BUSY cycle -> all outputs zero at the next edge, no Done pulse, and the subsequent ReqB is granted normally.
REQ-037 AddrA changes to 0xFFFFFFFC mid-BUSY and ReqA drops -> MemAddr stays 0x00000040, and DoneA still pulses.
